// File: rtl/sample_loader.sv
// sample_loader: buffers an N-sample frame, then copies it into the cache.
// Optional stall counter output: define SAMPLE_LOADER_STALL_CNT_EN.
module sample_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [11:0] sample_num,
  input  logic        load_nCompute,
  input  logic        load_to_cache,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [15:0] buf_wdata,
  output logic [11:0] buf_raddr,
  input  logic [15:0] buf_rdata,
  output logic        cache_we,
  output logic [11:0] cache_addr,
  output logic [15:0] cache_wdata,
  output logic        data_loaded,
  output logic        data_to_cache_loaded
`ifdef SAMPLE_LOADER_STALL_CNT_EN
  ,
  output logic [7:0]  stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FULL,
    COPY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [12:0] n_len;
  logic [12:0] wcnt;
  logic [12:0] rcnt;
  logic [11:0] caddr_q;
  logic        pend;
  logic        rd_q;
  logic [15:0] rdata_q;
  logic        start;
  logic        xfer;
  logic        rd_go;
  logic        rd_left;

  assign rd_left = (rcnt < n_len);

  // Next-state and handshake decode.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    xfer     = 1'b0;
    rd_go    = 1'b0;
    s_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ce && load_nCompute) begin
          start    = 1'b1;
          state_nx = FILL;
        end
      end
      FILL: begin
        s_ready = ce;
        xfer    = ce && s_valid;
        if (xfer && (wcnt == n_len - 13'd1))
          state_nx = FULL;
      end
      FULL: begin
        if (ce && load_to_cache)
          state_nx = COPY;
      end
      COPY: begin
        rd_go = ce && rd_left;
        if (ce && pend &&
            ({1'b0, caddr_q} == n_len - 13'd1))
          state_nx = DONE;
      end
      DONE: begin
        if (ce && !load_to_cache)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign buf_we    = xfer;
  assign buf_addr  = xfer ? wcnt[11:0] : 12'h0;
  assign buf_wdata = xfer ? s_data : 16'h0;
  assign buf_raddr = (state == COPY && rd_left) ?
                     rcnt[11:0] : 12'h0;

  assign cache_we    = pend && ce && (state == COPY);
  assign cache_addr  = cache_we ? caddr_q : 12'h0;
  assign cache_wdata = !cache_we ? 16'h0 :
                       rd_q ? buf_rdata : rdata_q;

  assign data_loaded          = (state == FULL);
  assign data_to_cache_loaded = (state == DONE);

  // State, frame length and address counters; all gated by ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      n_len   <= 13'd0;
      wcnt    <= 13'd0;
      rcnt    <= 13'd0;
      caddr_q <= 12'h0;
      pend    <= 1'b0;
    end else if (ce) begin
      state <= state_nx;
      pend  <= rd_go;
      if (start) begin
        n_len <= (sample_num == 12'h0) ?
                 13'd4096 : {1'b0, sample_num};
        wcnt  <= 13'd0;
      end
      if (xfer)
        wcnt <= wcnt + 13'd1;
      if (state == FULL)
        rcnt <= 13'd0;
      if (rd_go) begin
        rcnt    <= rcnt + 13'd1;
        caddr_q <= rcnt[11:0];
      end
    end
  end

  // Hold read data across ce=0 gaps so the cache sees the addressed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      rdata_q <= 16'h0;
    end else begin
      rd_q <= rd_go;
      if (rd_q)
        rdata_q <= buf_rdata;
    end
  end

`ifdef SAMPLE_LOADER_STALL_CNT_EN
  // Saturating count of refused samples outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 8'h0;
    end else if (ce) begin
      if (start)
        stall_cnt <= 8'h0;
      else if (s_valid && !s_ready &&
               state != IDLE &&
               stall_cnt != 8'hff)
        stall_cnt <= stall_cnt + 8'h1;
    end
  end
`endif

endmodule
